// File: rtl/reg_file_arbiter_if.sv
// reg_file_arbiter_if
//   Bundles every requester-side and register-file-side signal of the
//   reg_file_arbiter. The master modport is the environment: the two
//   requesters plus the register file's read-data pin. The slave modport
//   is the arbiter itself.
//   Requester A/B : Req, Wr, Addr, WrData in; Gnt, RdValid, RdData out
//   Register file : RF_WrEn, RF_RdEn, RF_Address, RF_WrData out; RF_RdData in
//   Status        : Busy out
interface reg_file_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  Req_A, Req_B;
  logic                  Wr_A, Wr_B;
  logic [ADDR_WIDTH-1:0] Addr_A, Addr_B;
  logic [DATA_WIDTH-1:0] WrData_A, WrData_B;
  logic                  Gnt_A, Gnt_B;
  logic                  RdValid_A, RdValid_B;
  logic [DATA_WIDTH-1:0] RdData_A, RdData_B;
  logic                  RF_WrEn, RF_RdEn;
  logic [ADDR_WIDTH-1:0] RF_Address;
  logic [DATA_WIDTH-1:0] RF_WrData;
  logic [DATA_WIDTH-1:0] RF_RdData;
  logic                  Busy;

  modport master (
    output Req_A, Req_B, Wr_A, Wr_B, Addr_A, Addr_B, WrData_A, WrData_B,
    output RF_RdData,
    input  Gnt_A, Gnt_B, RdValid_A, RdValid_B, RdData_A, RdData_B,
    input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData, Busy
  );

  modport slave (
    input  Req_A, Req_B, Wr_A, Wr_B, Addr_A, Addr_B, WrData_A, WrData_B,
    input  RF_RdData,
    output Gnt_A, Gnt_B, RdValid_A, RdValid_B, RdData_A, RdData_B,
    output RF_WrEn, RF_RdEn, RF_Address, RF_WrData, Busy
  );
endinterface

// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter
//   Shares a single-port 8x16 register file between requesters A and B.
//   One transaction at a time: IDLE samples requests and latches the
//   winner's command, ISSUE drives the register-file pins for one cycle,
//   RDWAIT (reads only) returns RF_RdData to the winner with RdValid.
//   Ports:
//     CLK  - system clock, rising edge
//     RST  - asynchronous active-low reset
//     bus  - reg_file_arbiter_if.slave (requester, register-file, Busy)
//   Configuration macro:
//     RF_ARB_FIXED_PRIO_EN - A always wins a tie (no round-robin pointer).
//                            Undefined: round-robin, favouring A after reset.
module reg_file_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                CLK,
  input  logic                RST,
  reg_file_arbiter_if.slave   bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;

  logic [1:0]            r_state;
  logic                  r_win;    // 0 = A owns the transaction, 1 = B
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic w_grant;
  logic w_pick_b;
  logic w_issue;
  logic w_rdwait;

  assign w_grant = (r_state == S_IDLE) && (bus.Req_A || bus.Req_B);

`ifdef RF_ARB_FIXED_PRIO_EN
  // B wins only when A is not asking.
  assign w_pick_b = bus.Req_B && !bus.Req_A;
`else
  // r_fav_b set means B wins the next tie; it flips toward whoever lost
  // (or did not request) on every grant.
  logic r_fav_b;

  assign w_pick_b = bus.Req_B && (!bus.Req_A || r_fav_b);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         r_fav_b <= 1'b0;
    else if (w_grant) r_fav_b <= !w_pick_b;
  end
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_win   <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_grant) begin
          r_win   <= w_pick_b;
          r_wr    <= w_pick_b ? bus.Wr_B     : bus.Wr_A;
          r_addr  <= w_pick_b ? bus.Addr_B   : bus.Addr_A;
          r_wdata <= w_pick_b ? bus.WrData_B : bus.WrData_A;
          r_state <= S_ISSUE;
        end
        S_ISSUE:  r_state <= r_wr ? S_IDLE : S_RDWAIT;
        S_RDWAIT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // All outputs decode from state alone, so an asynchronous reset clears
  // them at once and an abandoned transaction never produces Gnt/RdValid.
  assign w_issue  = (r_state == S_ISSUE);
  assign w_rdwait = (r_state == S_RDWAIT);

  assign bus.Gnt_A      = w_issue && !r_win;
  assign bus.Gnt_B      = w_issue &&  r_win;
  assign bus.RF_WrEn    = w_issue &&  r_wr;
  assign bus.RF_RdEn    = w_issue && !r_wr;
  assign bus.RF_Address = w_issue ? r_addr : '0;
  assign bus.RF_WrData  = (w_issue && r_wr) ? r_wdata : '0;

  assign bus.RdValid_A  = w_rdwait && !r_win;
  assign bus.RdValid_B  = w_rdwait &&  r_win;
  assign bus.RdData_A   = bus.RdValid_A ? bus.RF_RdData : '0;
  assign bus.RdData_B   = bus.RdValid_B ? bus.RF_RdData : '0;

  assign bus.Busy       = (r_state != S_IDLE);

endmodule

// File: doc/reg_file_arbiter.md
# reg_file_arbiter

Two-port arbiter that shares the single-port 8x16 register file between two requesters (A and B). It accepts read/write requests, grants one per transaction under round-robin priority, drives the register file's WrEn/RdEn/Address/WrData pins for exactly one cycle, and returns read data to the granted requester with a valid strobe. It sits between the requesting blocks and the register file, and is the only driver of the register file's access pins.

## Interface

- DATA_WIDTH, 16, register data width
- ADDR_WIDTH, 3, register address width (8 registers)
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- Req_A / Req_B  in  1  request from requester A / B
- Wr_A / Wr_B  in  1  1 = write, 0 = read
- Addr_A / Addr_B  in  ADDR_WIDTH  target register
- WrData_A / WrData_B  in  DATA_WIDTH  write data
- Gnt_A / Gnt_B  out  1  one-cycle grant pulse
- RdValid_A / RdValid_B  out  1  one-cycle read-data-valid pulse
- RdData_A / RdData_B  out  DATA_WIDTH  read data, meaningful only while the matching RdValid is high
- RF_WrEn  out  1  to register file WrEn
- RF_RdEn  out  1  to register file RdEn
- RF_Address  out  ADDR_WIDTH  to register file Address
- RF_WrData  out  DATA_WIDTH  to register file WrData
- RF_RdData  in  DATA_WIDTH  from register file RdData (updated on the edge where RdEn is high, held otherwise)
- Busy  out  1  high whenever the state is not IDLE

## Operation

- FSM states: IDLE, ISSUE, RDWAIT.
- IDLE: at each edge, sample Req_A and Req_B.
  - Neither asserted: stay in IDLE.
  - One asserted: grant that requester.
  - Both asserted: grant per the priority rule.
  - On grant: latch Wr, Addr and WrData of the winner into the command register, then go to ISSUE.
- ISSUE (one cycle):
  - Gnt of the winner is high.
  - RF_WrEn = latched Wr, RF_RdEn = ~latched Wr.
  - RF_Address and RF_WrData come from the command register.
  - Next state: IDLE for a write, RDWAIT for a read.
- RDWAIT (one cycle):
  - RF_RdEn = 0, RF_WrEn = 0.
  - RdValid of the winner is high; its RdData = RF_RdData, passed through combinationally.
  - Next state: IDLE.
- Priority rule: a round-robin pointer, updated on every grant to favour the requester that did not win. The pointer favours A after reset.
- Requester rule: hold Req and the command fields stable until Gnt is seen. Req sampled in the cycle after Gnt counts as a new request.
- Outside their active state, RF_WrEn, RF_RdEn, Gnt_* and RdValid_* are 0. RF_Address, RF_WrData and RdData_* are 0 when not in use.

## Timing

- Reset values: every output 0, state IDLE, pointer favours A.
- Reset is asynchronous. Asserting RST mid-transaction forces all outputs to 0 immediately and abandons the transaction: no Gnt and no RdValid are issued for it.
- Write, with Req high in cycle 0:
  - Gnt and RF_WrEn high in cycle 1.
  - Register file written at the end of cycle 1.
  - FSM back in IDLE in cycle 2.
  - Throughput: one write per 2 cycles.
- Read, with Req high in cycle 0:
  - Gnt and RF_RdEn high in cycle 1.
  - RdValid and RdData valid in cycle 2.
  - FSM back in IDLE in cycle 3.
  - Throughput: one read per 3 cycles.
- Requests arriving while Busy are not lost; they are sampled at the next IDLE edge.
- Simultaneous A and B requests: exactly one grant per transaction; the loser waits one transaction.
- Write followed by a read of the same register returns the new value; there is no hazard because writes complete before IDLE.

## Configuration

- RF_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, A always wins a tie; the pointer logic is removed.
  - Undefined (default): round-robin as described above.

## Test plan

- Reset: hold RST low, then release -> all outputs 0, Busy 0, state IDLE.
- A writes 17 to register 1, then A reads register 1 -> Gnt_A in cycle 1; on the read, RdValid_A is high 2 cycles after Req with RdData_A = 17; RdValid_B stays 0.
- A and B request in the same cycle repeatedly (A writes 10 to reg 4, B reads reg 4) -> grants alternate A, B, A, …; B's read returns 10. With RF_ARB_FIXED_PRIO_EN defined, A wins every tie.
- B holds Req high while A's read is in RDWAIT -> B's request is granted in the first ISSUE after IDLE, and nothing is dropped.
- RST asserted during ISSUE of a read -> RF_RdEn, Gnt_* and RdValid_* drop immediately, and no RdValid follows after reset is released.
- No Req for 20 cycles after a write of 15 to reg 2 -> RF_WrEn and RF_RdEn stay 0 throughout; a subsequent read of reg 2 returns 15.
